// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared constants and types for the bidirectional shift link.
//               The receiving shift register uses the same mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Receiver shift-mode control encodings
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;   // LSB-first transmit
    localparam logic [1:0] MODE_SHL  = 2'b10;   // MSB-first transmit

    // Serializer control states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Any mode other than shift-left is treated as shift-right (LSB-first)
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == MODE_SHL) ? MODE_SHL : MODE_SHR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serializer_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : serializer_hold_buf
// Description : One-entry data+mode holding register with a full flag.
//               A load sets full; a take without a load clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module serializer_hold_buf
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] load_data,
    input  logic [1:0]       load_mode,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       mode,
    output logic             full
);

    // Capture an incoming word and track occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            mode <= MODE_SHR;
            full <= 1'b0;
        end else begin
            if (load) begin
                data <= load_data;
                mode <= load_mode;
            end
            if (load) begin
                full <= 1'b1;
            end else if (take) begin
                full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bidir_shift_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bidir_shift_serializer
// Description : Parallel-in/serial-out transmitter feeding a bidirectional
//               shift register. Shifts each word LSB- or MSB-first and drives
//               the matching receiver shift-mode so the receiver ends up with
//               the word in its original bit order. A one-entry holding
//               buffer lets frames run back to back without a gap cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bidir_shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             pause,
    output logic             sout,
    output logic [1:0]       rx_mode,
    output logic             frame_done,
    output logic             busy
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic               r_dir;          // 1 = MSB-first
    logic               w_dir_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;

    logic               w_accept;
    logic               w_active;
    logic               w_free;
    logic               w_buf_load;
    logic               w_buf_take;
    logic               w_buf_full;
    logic [WIDTH-1:0]   w_buf_data;
    logic [1:0]         w_buf_mode;

    assign in_ready   = !w_buf_full;
    assign w_accept   = in_valid && in_ready;
    assign w_active   = (r_state == SHIFT) && !pause;
    // The shifter can take a new word when idle or while finishing its last bit
    assign w_free     = (r_state == IDLE) || (w_active && (r_cnt == C_LAST));
    // A word only parks in the buffer when the shifter is still occupied
    assign w_buf_load = w_accept && !w_free;
    assign w_buf_take = w_free && w_buf_full;

    serializer_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_buf_load),
        .take      (w_buf_take),
        .load_data (in_data),
        .load_mode (norm_mode(in_mode)),
        .data      (w_buf_data),
        .mode      (w_buf_mode),
        .full      (w_buf_full)
    );

    // State, shifter, direction and bit-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, load/shift selection and serial-side outputs
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        sout        = 1'b0;
        rx_mode     = MODE_HOLD;
        frame_done  = 1'b0;
        busy        = (r_state == SHIFT);

        if (w_free) begin
            if (w_buf_full) begin
                // Buffered word has priority; the input is blocked anyway
                w_state_nxt = SHIFT;
                w_sreg_nxt  = w_buf_data;
                w_dir_nxt   = (w_buf_mode == MODE_SHL);
                w_cnt_nxt   = '0;
            end else if (w_accept) begin
                w_state_nxt = SHIFT;
                w_sreg_nxt  = in_data;
                w_dir_nxt   = (norm_mode(in_mode) == MODE_SHL);
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        end else if (w_active) begin
            w_sreg_nxt = r_dir ? (r_sreg << 1) : (r_sreg >> 1);
            w_cnt_nxt  = r_cnt + CW'(1);
        end

        if (r_state == SHIFT) begin
            sout = r_dir ? r_sreg[WIDTH-1] : r_sreg[0];
        end
        if (w_active) begin
            rx_mode    = r_dir ? MODE_SHL : MODE_SHR;
            frame_done = (r_cnt == C_LAST);
        end
    end

endmodule
`default_nettype wire
